shift_request_sequencer: RTL and testbench

Multi-cycle logical shift engine shared by two requesters. It accepts a shift request (data, amount, direction) from one of two ports under round-robin arbitration. The request executes on a single fixed-step shifter: each cycle moves the word by S bits or by 1 bit. The result is returned on one valid/ready output port. The block sits between client logic and the fixed-S shift datapath, so that arbitrary shift amounts are supported without a full barrel shifter.

---
 rtl/shift_request_sequencer_if.sv | 46 ++++
 rtl/shift_request_sequencer.sv | 142 ++++++++++++++
 tb/tb_shift_request_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_request_sequencer_if.sv
// Request/result bundle for shift_request_sequencer.
// master: requesters plus result consumer; slave: the sequencer itself.
interface shift_request_sequencer_if #(
  parameter int N  = 8,
  parameter int AW = 4
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [N-1:0]  req_data0;
  logic [N-1:0]  req_data1;
  logic [AW-1:0] req_amt0;
  logic [AW-1:0] req_amt1;
  logic [1:0]    req_dir;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic          out_id;

  modport master (
    output req_valid,
    output req_data0,
    output req_data1,
    output req_amt0,
    output req_amt1,
    output req_dir,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_id
  );

  modport slave (
    input  req_valid,
    input  req_data0,
    input  req_data1,
    input  req_amt0,
    input  req_amt1,
    input  req_dir,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_id
  );
endinterface

// File: rtl/shift_request_sequencer.sv
// Two-port round-robin multi-cycle logical shifter (fixed S-bit or 1-bit steps).
// Ports: clk, rst (async high), bus (slave: requests in, result out), busy.
module shift_request_sequencer #(
  parameter int N  = 8,
  parameter int S  = 3,
  parameter int AW = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  shift_request_sequencer_if.slave  bus,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [AW-1:0] N_AW = AW'(N);
  localparam logic [AW-1:0] S_AW = AW'(S);

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  word;
  logic [N-1:0]  word_nx;
  logic [AW-1:0] rem;
  logic [AW-1:0] rem_nx;
  logic          dir;
  logic          dir_nx;
  logic          id;
  logic          id_nx;
  logic          rr_last;
  logic          rr_last_nx;

  logic          any_valid;
  logic          winner;
  logic          accept;
  logic [N-1:0]  sel_data;
  logic [AW-1:0] sel_amt;
  logic [AW-1:0] sat_amt;
  logic          sel_dir;
  logic          big_step;
  logic [N-1:0]  stepped;
  logic [AW-1:0] rem_step;

  // With both ports asking, the one not served last wins.
  always_comb begin
    any_valid = |bus.req_valid;
    if (&bus.req_valid) begin
      winner = ~rr_last;
    end else begin
      winner = bus.req_valid[1];
    end
    accept = (state == IDLE) && any_valid;
    bus.req_ready = 2'b00;
    if (accept) begin
      bus.req_ready = winner ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    sel_data = winner ? bus.req_data1 : bus.req_data0;
    sel_amt  = winner ? bus.req_amt1  : bus.req_amt0;
    sel_dir  = bus.req_dir[winner];
    // Saturating at N keeps latency bounded; result is zero anyway.
    sat_amt  = (sel_amt > N_AW) ? N_AW : sel_amt;
  end

  // Single fixed-step datapath: S bits when enough remain, else 1.
  always_comb begin
    big_step = (rem >= S_AW);
    if (big_step) begin
      stepped  = dir ? (word >> S) : (word << S);
      rem_step = rem - S_AW;
    end else begin
      stepped  = dir ? (word >> 1) : (word << 1);
      rem_step = rem - AW'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    word_nx    = word;
    rem_nx     = rem;
    dir_nx     = dir;
    id_nx      = id;
    rr_last_nx = rr_last;
    unique case (state)
      IDLE: begin
        if (accept) begin
          word_nx    = sel_data;
          rem_nx     = sat_amt;
          dir_nx     = sel_dir;
          id_nx      = winner;
          rr_last_nx = winner;
          state_nx   = (sat_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        word_nx = stepped;
        rem_nx  = rem_step;
        if (rem_step == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      word    <= '0;
      rem     <= '0;
      dir     <= 1'b0;
      id      <= 1'b0;
      rr_last <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      word    <= word_nx;
      rem     <= rem_nx;
      dir     <= dir_nx;
      id      <= id_nx;
      rr_last <= rr_last_nx;
      busy    <= (state_nx != IDLE);
    end
  end

  always_comb begin
    bus.out_valid = (state == DONE);
    bus.out_data  = word;
    bus.out_id    = id;
  end

endmodule

// File: tb/tb_shift_request_sequencer.sv
// Directed self-checking bench for shift_request_sequencer.
// N=8, S=3, AW=4; inputs driven 1 time unit after rising edges.
module tb_shift_request_sequencer;

  logic clk;
  logic rst;
  logic busy;
  int   tests;
  int   fails;

  shift_request_sequencer_if #(.N(8), .AW(4)) bus ();

  shift_request_sequencer #(.N(8), .S(3), .AW(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait for its result (out_ready assumed 1).
  task automatic do_req(
    input  int         p,
    input  logic [7:0] d,
    input  logic [3:0] a,
    input  logic       dr,
    output int         lat,
    output logic [7:0] od,
    output logic       oid,
    output logic       ok
  );
    int w;
    if (p == 0) begin
      bus.req_data0 = d;
      bus.req_amt0  = a;
    end else begin
      bus.req_data1 = d;
      bus.req_amt1  = a;
    end
    bus.req_dir[p]   = dr;
    bus.req_valid[p] = 1'b1;
    #1;
    w = 0;
    while (!bus.req_ready[p] && w < 20) begin
      @(posedge clk);
      #2;
      w++;
    end
    ok = bus.req_ready[p];
    @(posedge clk);
    #1;
    bus.req_valid[p] = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    od  = bus.out_data;
    oid = bus.out_id;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 ||
        bus.out_id !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b d=%h id=%b busy=%b, want 0 00 0 0",
               bus.out_valid, bus.out_data, bus.out_id, busy);
    end
    tests++;
    if (bus.req_ready !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready_none: got %b want 00", bus.req_ready);
    end
    bus.req_valid = 2'b11;
    #1;
    tests++;
    if (bus.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL reset_ready_both: got %b want 01", bus.req_ready);
    end
    bus.req_valid = 2'b10;
    #1;
    tests++;
    if (bus.req_ready !== 2'b10) begin
      fails++;
      $display("FAIL reset_ready_p1: got %b want 10", bus.req_ready);
    end
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_left();
    int lat;
    logic [7:0] od;
    logic oid, ok;
    do_req(0, 8'b1011_0111, 4'd5, 1'b0, lat, od, oid, ok);
    tests++;
    if (!ok || lat != 3 || od !== 8'b1110_0000 || oid !== 1'b0) begin
      fails++;
      $display("FAIL left_shift: got ok=%b k=%0d d=%h id=%b, want 1 3 e0 0",
               ok, lat, od, oid);
    end
  endtask

  task automatic test_right();
    int lat;
    logic [7:0] od;
    logic oid, ok;
    do_req(1, 8'hFF, 4'd7, 1'b1, lat, od, oid, ok);
    tests++;
    if (!ok || lat != 3 || od !== 8'h01 || oid !== 1'b1) begin
      fails++;
      $display("FAIL right_shift: got ok=%b k=%0d d=%h id=%b, want 1 3 01 1",
               ok, lat, od, oid);
    end
  endtask

  task automatic test_boundary();
    int lat;
    logic [7:0] od;
    logic oid, ok;
    do_req(0, 8'hA5, 4'd0, 1'b0, lat, od, oid, ok);
    tests++;
    if (!ok || lat != 0 || od !== 8'hA5) begin
      fails++;
      $display("FAIL amt0: got ok=%b k=%0d d=%h, want 1 0 a5", ok, lat, od);
    end
    do_req(0, 8'hFF, 4'd9, 1'b0, lat, od, oid, ok);
    tests++;
    if (!ok || lat != 4 || od !== 8'h00) begin
      fails++;
      $display("FAIL amt9_left: got ok=%b k=%0d d=%h, want 1 4 00", ok, lat, od);
    end
    do_req(1, 8'hFF, 4'd8, 1'b1, lat, od, oid, ok);
    tests++;
    if (!ok || lat != 4 || od !== 8'h00) begin
      fails++;
      $display("FAIL amt8_right: got ok=%b k=%0d d=%h, want 1 4 00", ok, lat, od);
    end
    do_req(1, 8'h0F, 4'd4, 1'b0, lat, od, oid, ok);
    tests++;
    if (!ok || lat != 2 || od !== 8'hF0 || oid !== 1'b1) begin
      fails++;
      $display("FAIL amt4_left: got ok=%b k=%0d d=%h id=%b, want 1 2 f0 1",
               ok, lat, od, oid);
    end
  endtask

  task automatic test_arbitration();
    logic       g[4];
    logic       oi[4];
    logic [7:0] dd[4];
    int ng;
    int no;
    int lat;
    logic [7:0] od;
    logic oid, ok, ok2;
    do_reset();
    bus.req_data0 = 8'h01;
    bus.req_amt0  = 4'd1;
    bus.req_data1 = 8'h80;
    bus.req_amt1  = 4'd1;
    bus.req_dir   = 2'b10;
    bus.req_valid = 2'b11;
    ng = 0;
    no = 0;
    for (int c = 0; c < 100 && no < 4; c++) begin
      #1;
      if (bus.req_ready != 2'b00 && ng < 4) begin
        g[ng] = bus.req_ready[1];
        ng++;
      end
      if (bus.out_valid && no < 4) begin
        oi[no] = bus.out_id;
        dd[no] = bus.out_data;
        no++;
      end
      @(posedge clk);
      #1;
    end
    bus.req_valid = 2'b00;
    tests++;
    if (ng != 4 || no != 4) begin
      fails++;
      $display("FAIL arb_count: got grants=%0d outs=%0d, want 4 4", ng, no);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (g[i] !== i[0] || oi[i] !== i[0] ||
            dd[i] !== (i[0] ? 8'h40 : 8'h02)) begin
          fails++;
          $display("FAIL arb_seq%0d: got grant=%b id=%b d=%h, want %b %b %h",
                   i, g[i], oi[i], dd[i], i[0], i[0], i[0] ? 8'h40 : 8'h02);
        end
      end
    end
    @(posedge clk);
    #1;
    do_req(0, 8'h03, 4'd3, 1'b0, lat, od, oid, ok);
    do_req(0, 8'h03, 4'd2, 1'b0, lat, od, oid, ok2);
    tests++;
    if (!ok || !ok2 || oid !== 1'b0 || od !== 8'h0C) begin
      fails++;
      $display("FAIL arb_p0_twice: got ok=%b%b id=%b d=%h, want 11 0 0c",
               ok, ok2, oid, od);
    end
  endtask

  task automatic test_backpressure();
    int w;
    bus.out_ready = 1'b0;
    bus.req_data1 = 8'h0F;
    bus.req_amt1  = 4'd2;
    bus.req_dir   = 2'b00;
    bus.req_valid = 2'b10;
    #1;
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    w = 0;
    while (!bus.out_valid && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    bus.req_data0 = 8'h11;
    bus.req_amt0  = 4'd0;
    bus.req_valid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h3C ||
          bus.out_id !== 1'b1 || bus.req_ready !== 2'b00 || busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b d=%h id=%b rdy=%b busy=%b, want 1 3c 1 00 1",
                 c, bus.out_valid, bus.out_data, bus.out_id, bus.req_ready, busy);
      end
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2;
    tests++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL bp_release: got v=%b busy=%b rdy=%b, want 0 0 01",
               bus.out_valid, busy, bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    #1;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 ||
        bus.out_id !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL bp_next: got v=%b d=%h id=%b busy=%b, want 1 11 0 1",
               bus.out_valid, bus.out_data, bus.out_id, busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    logic seen;
    bus.req_data0 = 8'hFF;
    bus.req_amt0  = 4'd7;
    bus.req_dir   = 2'b00;
    bus.req_valid = 2'b01;
    #1;
    @(posedge clk);
    #1;
    bus.req_valid = 2'b00;
    @(posedge clk);
    #1;
    tests++;
    if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_shift: got busy=%b v=%b, want 1 0", busy, bus.out_valid);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got busy=%b v=%b, want 0 0", busy, bus.out_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || busy) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL mid_no_result: got activity=%b want 0", seen);
    end
    bus.req_valid = 2'b11;
    #1;
    tests++;
    if (bus.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL mid_first_grant: got %b want 01", bus.req_ready);
    end
    bus.req_valid = 2'b00;
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b0;
    bus.req_valid = 2'b00;
    bus.req_data0 = 8'h00;
    bus.req_data1 = 8'h00;
    bus.req_amt0  = 4'd0;
    bus.req_amt1  = 4'd0;
    bus.req_dir   = 2'b00;
    bus.out_ready = 1'b1;
    test_reset();
    test_left();
    test_right();
    test_boundary();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
